// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory responder with wait-state latency
// Optional fault reporting for out-of-range addresses is enabled by defining MEM_RESP_ERR_EN.
module mem_responder #(
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_write;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH];

  logic w_accept;
  logic w_enter_resp;
  logic w_release;
  logic w_fault;
  logic w_commit;

  assign w_accept     = req_valid && req_ready;
  // Counter starts at LATENCY-1 and the RESP entry happens on the edge after it reaches 0,
  // which puts resp_valid high exactly LATENCY edges after acceptance.
  assign w_enter_resp = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_release    = (r_state == RESP) && resp_valid && resp_ready;
  assign w_commit     = w_enter_resp && r_write && !w_fault;

`ifdef MEM_RESP_ERR_EN
  logic r_fault;
  assign w_fault = r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault  <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      if (w_accept)
        r_fault <= (req_addr >= 32'(DEPTH));
      if (w_enter_resp)
        resp_err <= r_fault;
      else if (w_release)
        resp_err <= 1'b0;
    end
  end
`else
  logic w_unused_addr;
  assign w_fault       = 1'b0;
  assign resp_err      = 1'b0;
  assign w_unused_addr = &{1'b0, req_addr[31:AW]};
`endif

  // Storage is not reset; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && w_commit)
      r_mem[r_idx] <= r_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      r_cnt      <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write   <= req_write;
            r_idx     <= req_addr[AW-1:0];
            r_wdata   <= req_wdata;
            r_cnt     <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (w_enter_resp) begin
            resp_valid <= 1'b1;
            resp_rdata <= (r_write || w_fault) ? 32'd0 : r_mem[r_idx];
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (w_release) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            req_ready  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (LATENCY=2 and LATENCY=1 instances)
module tb_mem_responder;

  localparam int D0 = 2048;
  localparam int L0 = 2;
  localparam int D1 = 64;
  localparam int L1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv  [2];
  logic        rw  [2];
  logic        rr  [2];
  logic [31:0] ra  [2];
  logic [31:0] wd  [2];
  logic        rdy [2];
  logic        vld [2];
  logic        err [2];
  logic [31:0] rd  [2];

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int last_acc [2];
  logic [31:0] mdl [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DEPTH(D0), .LATENCY(L0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(wd[0]),
    .resp_valid(vld[0]), .resp_ready(rr[0]), .resp_rdata(rd[0]), .resp_err(err[0])
  );

  mem_responder #(.DEPTH(D1), .LATENCY(L1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(wd[1]),
    .resp_valid(vld[1]), .resp_ready(rr[1]), .resp_rdata(rd[1]), .resp_err(err[1])
  );

  function automatic int lat_of(input int s);
    return (s == 0) ? L0 : L1;
  endfunction

  function automatic int dep_of(input int s);
    return (s == 0) ? D0 : D1;
  endfunction

  function automatic bit is_fault(input int s, input logic [31:0] addr);
`ifdef MEM_RESP_ERR_EN
    return addr >= 32'(dep_of(s));
`else
    return (addr != addr);
`endif
  endfunction

  function automatic int key_of(input int s, input logic [31:0] addr);
    return s * 100000 + int'(addr % 32'(dep_of(s)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request/response. hold = cycles of resp_ready=0 backpressure,
  // b2b = check acceptance spacing against the previous one, poke = try a
  // competing request while the responder is busy.
  task automatic xact(input int s, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input int hold, input bit b2b, input bit poke);
    int          lat;
    int          t;
    int          key;
    bit          flt;
    logic [31:0] exp_rd;
    logic        exp_err;
    lat = lat_of(s);
    key = key_of(s, addr);
    flt = is_fault(s, addr);
    t   = 0;
    while (!rdy[s] && t < 50) begin
      step();
      t++;
    end
    chk("req_ready_before_accept", 32'(rdy[s]), 32'd1);
    rr[s] = (hold == 0);
    rv[s] = 1'b1;
    rw[s] = wr;
    ra[s] = addr;
    wd[s] = data;
    step();
    if (b2b) chk("accept_spacing", 32'(cyc - last_acc[s]), 32'(lat + 2));
    last_acc[s] = cyc;
    rv[s] = 1'b0;
    rw[s] = 1'($urandom);
    ra[s] = $urandom;
    wd[s] = $urandom;
    if (flt) begin
      exp_rd  = 32'd0;
      exp_err = 1'b1;
    end else if (wr) begin
      exp_rd  = 32'd0;
      exp_err = 1'b0;
      mdl[key] = data;
    end else begin
      exp_rd  = mdl[key];
      exp_err = 1'b0;
    end
    for (int k = 0; k < lat; k++) begin
      chk("valid_low_during_wait", 32'(vld[s]), 32'd0);
      chk("ready_low_during_wait", 32'(rdy[s]), 32'd0);
      step();
    end
    chk("resp_valid_at_latency", 32'(vld[s]), 32'd1);
    chk("resp_rdata", rd[s], exp_rd);
    chk("resp_err", 32'(err[s]), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        rv[s] = 1'b1;
        rw[s] = 1'b1;
        ra[s] = addr;
        wd[s] = ~data;
      end
      step();
      chk("held_valid", 32'(vld[s]), 32'd1);
      chk("held_rdata", rd[s], exp_rd);
      chk("held_err", 32'(err[s]), 32'(exp_err));
      chk("held_ready_low", 32'(rdy[s]), 32'd0);
    end
    rv[s] = 1'b0;
    rr[s] = 1'b1;
    step();
    chk("released_valid", 32'(vld[s]), 32'd0);
    chk("released_rdata", rd[s], 32'd0);
    chk("released_err", 32'(err[s]), 32'd0);
    chk("released_ready", 32'(rdy[s]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          wr;
    bit          prev_zero_hold;
    int          hold;
    logic [31:0] addr;
    for (int s = 0; s < 2; s++) begin
      rv[s] = 1'b0; rw[s] = 1'b0; rr[s] = 1'b0; ra[s] = 32'd0; wd[s] = 32'd0;
      last_acc[s] = 0;
    end
    rst = 1'b1;
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      chk("reset_req_ready", 32'(rdy[s]), 32'd1);
      chk("reset_resp_valid", 32'(vld[s]), 32'd0);
      chk("reset_resp_rdata", rd[s], 32'd0);
      chk("reset_resp_err", 32'(err[s]), 32'd0);
    end
    rst = 1'b0;
    step();

    // Store then load, then backpressure with a competing request.
    xact(0, 1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    xact(0, 1'b0, 32'd5, 32'd0, 0, 1'b1, 1'b0);
    xact(0, 1'b0, 32'd5, 32'd0, 4, 1'b0, 1'b1);
    xact(0, 1'b0, 32'd5, 32'd0, 0, 1'b0, 1'b0);

    // Address wrap (or fault when enabled).
    xact(0, 1'b1, 32'd7, 32'h0BADF00D, 0, 1'b0, 1'b0);
    xact(0, 1'b1, 32'd2048 + 32'd7, 32'h12345678, 0, 1'b1, 1'b0);
    xact(0, 1'b0, 32'd7, 32'd0, 0, 1'b1, 1'b0);

    // Reset while a store is waiting discards it.
    xact(0, 1'b1, 32'd9, 32'h11111111, 0, 1'b0, 1'b0);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'd9; wd[0] = 32'hA5A5A5A5; rr[0] = 1'b1;
    step();
    rv[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midop_reset_ready", 32'(rdy[0]), 32'd1);
    chk("midop_reset_valid", 32'(vld[0]), 32'd0);
    chk("midop_reset_rdata", rd[0], 32'd0);
    chk("midop_reset_err", 32'(err[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midop_no_late_resp", 32'(vld[0]), 32'd0);
    end
    xact(0, 1'b0, 32'd9, 32'd0, 0, 1'b0, 1'b0);

    // LATENCY=1 back-to-back loads.
    xact(1, 1'b1, 32'd3, 32'hCAFE0003, 0, 1'b0, 1'b0);
    xact(1, 1'b0, 32'd3, 32'd0, 0, 1'b1, 1'b0);
    xact(1, 1'b0, 32'd3, 32'd0, 0, 1'b1, 1'b0);
    xact(1, 1'b0, 32'd64 + 32'd3, 32'd0, 0, 1'b1, 1'b0);

    // Randomized traffic against the model on both instances.
    for (int s = 0; s < 2; s++) begin
      prev_zero_hold = 1'b0;
      for (int i = 0; i < 30; i++) begin
        wr   = 1'($urandom);
        addr = 32'($urandom_range(0, 15)) + 32'(dep_of(s)) * 32'($urandom_range(0, 2));
        hold = (($urandom & 32'h3) == 0) ? int'($urandom_range(1, 3)) : 0;
        if (!wr && !is_fault(s, addr) && !mdl.exists(key_of(s, addr)))
          wr = 1'b1;
        xact(s, wr, addr, $urandom, hold, prev_zero_hold, hold > 0 && (i % 2 == 0));
        prev_zero_hold = (hold == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
